muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the five-stage MIPS pipeline. It sits in EX next to the combinational ALU, takes the same forwarded operands (x, y), and replaces the ALU's single-cycle multiply and divide with a 33-cycle sequential engine. Its HI/LO results are read by mfhi/mflo. While `busy` is high, the hazard unit stalls any instruction that touches HI/LO.

---
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle multiply/divide engine with HI/LO registers.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   start, op, x, y   - launch request, op select (00 mult, 01 multu, 10 div, 11 divu), operands
//   we_hi, we_lo,     - mthi/mtlo write strobes and data (ignored while busy)
//   wdata
//   busy, done, dbz   - in-progress flag, one-cycle completion pulse, last divide had y=0
//   hi, lo            - architectural HI/LO registers
module muldiv_unit #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         we_hi,
  input  logic         we_lo,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         dbz,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [1:0]     op_q, op_d;
  logic           sx_q, sx_d;
  logic           sy_q, sy_d;
  logic           yz_q, yz_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           is_signed;
  logic [W-1:0]   abs_x, abs_y;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shl;
  logic [W:0]     div_diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_d     = op_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    yz_d     = yz_q;
    x_d      = x_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;

    // Operand magnitudes: only the signed ops (op[0]=0) take absolute values
    is_signed = ~op[0];
    abs_x     = (is_signed && x[W-1]) ? W'(-x) : x;
    abs_y     = (is_signed && y[W-1]) ? W'(-y) : y;

    // Shift-add step: multiplier sits in acc low half, consumed LSB first
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : (W+1)'(0));
    // Restoring step: dividend/quotient share acc low half, MSB first
    div_shl  = {rem_q[W-1:0], acc_q[W-1]};
    div_diff = div_shl - {1'b0, b_q};

    prod_fix = (sx_q ^ sy_q) ? (2*W)'(-acc_q) : acc_q;
    quo_fix  = (sx_q ^ sy_q) ? W'(-acc_q[W-1:0]) : acc_q[W-1:0];
    rem_fix  = sx_q ? W'(-rem_q[W-1:0]) : rem_q[W-1:0];

    // mthi/mtlo only when idle; a later result overwrites them
    if (!busy_q) begin
      if (we_hi) hi_d = wdata;
      if (we_lo) lo_d = wdata;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          op_d    = op;
          sx_d    = is_signed & x[W-1];
          sy_d    = is_signed & y[W-1];
          yz_d    = (y == '0);
          x_d     = x;
          a_d     = abs_x;
          b_d     = abs_y;
          acc_d   = op[1] ? {{W{1'b0}}, abs_x} : {{W{1'b0}}, abs_y};
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        if (op_q[1]) begin
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_diff[W]};
          rem_d = div_diff[W] ? div_shl : div_diff;
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(31)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (op_q[1]) begin
          if (yz_q) begin
            lo_d  = '1;
            hi_d  = x_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      yz_q    <= 1'b0;
      x_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      yz_q    <= yz_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] x, y;
  logic        we_hi, we_lo;
  logic [31:0] wdata;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  int cyc;

  muldiv_unit #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Caller is at a negedge; drive start for one edge, return at the next negedge
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; x = a; y = b;
    @(negedge clk);
    start = 1'b0; op = 2'b00; x = 32'h0BAD_0BAD; y = 32'h0BAD_0BAD;
  endtask

  // Count negedges until busy drops (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; x = '0; y = '0;
    we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (dbz !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
    vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi, lo); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_signed_mult;
    launch(2'b00, 32'hFFFF_FFFD, 32'd7);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mult_busy_rise: got %b expected 1", busy); end
    wait_idle(cyc);
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL mult_done: got %b expected 1", done); end
    vectors++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mult_result: got %h_%h expected ffffffff_ffffffeb", hi, lo); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mult_done_fall: got %b expected 0", done); end
  endtask

  task automatic test_back_to_back;
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(cyc);
    vectors++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", hi, lo); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL multu_done: got %b expected 1", done); end
    launch(2'b00, 32'd5, 32'd6);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    vectors++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin miscompares++; $display("FAIL b2b_hold: got %h_%h expected fffffffe_00000001", hi, lo); end
    wait_idle(cyc);
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 33", cyc); end
    vectors++; if (hi !== 32'h0 || lo !== 32'd30) begin miscompares++; $display("FAIL b2b_result: got %h_%h expected 0_1e", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_div;
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    vectors++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_signed: got lo=%h hi=%h expected fffffffd/ffffffff", lo, hi); end
    vectors++; if (dbz !== 1'b0) begin miscompares++; $display("FAIL div_dbz: got %b expected 0", dbz); end
    @(negedge clk);
    launch(2'b11, 32'd100, 32'd7);
    wait_idle(cyc);
    vectors++; if (lo !== 32'd14 || hi !== 32'd2) begin miscompares++; $display("FAIL divu: got lo=%h hi=%h expected e/2", lo, hi); end
    @(negedge clk);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    vectors++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin miscompares++; $display("FAIL div_overflow: got lo=%h hi=%h expected 80000000/0", lo, hi); end
    @(negedge clk);
    launch(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_idle(cyc);
    vectors++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin miscompares++; $display("FAIL div_negdivisor: got lo=%h hi=%h expected fffffffd/1", lo, hi); end
    @(negedge clk);
  endtask

  task automatic test_dbz;
    launch(2'b11, 32'd100, 32'd0);
    wait_idle(cyc);
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL dbz_latency: got %0d expected 33", cyc); end
    vectors++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h64) begin miscompares++; $display("FAIL dbz_result: got lo=%h hi=%h expected ffffffff/64", lo, hi); end
    vectors++; if (dbz !== 1'b1) begin miscompares++; $display("FAIL dbz_set: got %b expected 1", dbz); end
    @(negedge clk);
    vectors++; if (dbz !== 1'b1) begin miscompares++; $display("FAIL dbz_hold: got %b expected 1", dbz); end
    launch(2'b00, 32'd1, 32'd1);
    vectors++; if (dbz !== 1'b0) begin miscompares++; $display("FAIL dbz_clear: got %b expected 0", dbz); end
    wait_idle(cyc);
    @(negedge clk);
  endtask

  task automatic test_busy_protect;
    launch(2'b00, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b10; x = 32'd50; y = 32'd5;
    we_hi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; we_hi = 1'b0;
    vectors++; if (hi !== 32'h0 || lo !== 32'h1) begin miscompares++; $display("FAIL busy_hilo_stable: got %h_%h expected 0_1", hi, lo); end
    wait_idle(cyc);
    vectors++; if (hi !== 32'h0 || lo !== 32'd12) begin miscompares++; $display("FAIL busy_ignore: got %h_%h expected 0_c", hi, lo); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_no_restart: got %b expected 0", busy); end
    we_hi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    we_hi = 1'b0;
    vectors++; if (hi !== 32'hDEAD_BEEF || lo !== 32'd12) begin miscompares++; $display("FAIL mthi: got %h_%h expected deadbeef_c", hi, lo); end
    we_lo = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    we_lo = 1'b0;
    vectors++; if (lo !== 32'h1234_5678 || hi !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mtlo: got %h_%h expected deadbeef_12345678", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    launch(2'b10, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("FAIL midreset_state: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", pulses); end
    launch(2'b00, 32'd2, 32'd2);
    wait_idle(cyc);
    vectors++; if (cyc !== 33 || lo !== 32'd4 || hi !== 32'h0) begin miscompares++; $display("FAIL midreset_recover: got cyc=%0d %h_%h expected 33 0_4", cyc, hi, lo); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_signed_mult();
    test_back_to_back();
    test_div();
    test_dbz();
    test_busy_protect();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
